// File: rtl/mux_rr_nx1_pkg.sv
// Shared constants and helpers for the N:1 valid/ready merge.
package mux_rr_nx1_pkg;

    localparam int MODE_FIXED = 32'sd0;
    localparam int MODE_RR    = 32'sd1;

    // Index width needed to name n channels; never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            r = ((32'sd1 << i) < n) ? (i + 32'sd1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_nx1_if.sv
// Valid/ready bundle between N producers, the merge and one consumer.
interface mux_rr_nx1_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    import mux_rr_nx1_pkg::*;

    localparam int SELW = clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    // Producer/consumer side of the merge.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // The merge itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux_rr_nx1_arb.sv
// Combinational arbiter: rotates the request vector so the scan starts at
// ptr, picks the lowest set bit, then maps the offset back to a channel.
module rr_arbiter
    import mux_rr_nx1_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR
) (
    input  logic [N-1:0]         req_i,
    input  logic [clog2(N)-1:0]  ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [clog2(N)-1:0]  gidx_o
);

    localparam int SELW = clog2(N);
    localparam int SW1  = SELW + 1;
    localparam logic [SW1-1:0] N_W = SW1'(N);

    logic [SELW-1:0]  eff_ptr_s;
    logic [2*N-1:0]   req_dbl_s;
    logic [N-1:0]     rot_s;
    logic             found_s;
    logic [SELW-1:0]  off_s;
    logic [SW1-1:0]   sum_s;

    // Rotate-and-priority-encode; fixed priority simply never rotates.
    always_comb begin
        eff_ptr_s = (MODE == MODE_RR) ? ptr_i : {SELW{1'b0}};
        req_dbl_s = {req_i, req_i};
        rot_s     = req_dbl_s[eff_ptr_s +: N];
        found_s   = |rot_s;
        off_s     = {SELW{1'b0}};
        // Descending scan so the lowest set offset wins.
        for (int k = N - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? SELW'(k) : off_s;
        end
        sum_s   = {1'b0, eff_ptr_s} + {1'b0, off_s};
        // Wrap back into 0..N-1; correct for non-power-of-two N too.
        gidx_o  = (sum_s >= N_W) ? SELW'(sum_s - N_W) : sum_s[SELW-1:0];
        grant_o = found_s ? ({{(N-1){1'b0}}, 1'b1} << gidx_o) : {N{1'b0}};
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// N:1 valid/ready merge with a registered output stage and round-robin or
// fixed-priority arbitration. Sustains one beat per cycle.
module mux_rr_nx1
    import mux_rr_nx1_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_RR
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_rr_nx1_if.slave  bus
);

    localparam int SELW = clog2(N);

    logic [N-1:0]     grant_s;
    logic [SELW-1:0]  gidx_s;
    logic             load_s;
    logic [N-1:0]     in_ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;

    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .req_i   (bus.in_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .gidx_o  (gidx_s)
    );

    // Handshake: accept only when the output slot is free or draining;
    // reset also blocks acceptance since the register is held clear.
    always_comb begin
        load_s     = !out_valid_q || bus.out_ready;
        in_ready_s = (rst_n && load_s) ? grant_s : {N{1'b0}};
        xfer_s     = |in_ready_s;
    end

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_data_s = sel_data_s | ({WIDTH{grant_s[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
        end
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_sel_d   = gidx_s;
            if (MODE == MODE_RR) begin
                ptr_d = (gidx_s == SELW'(N - 1)) ? {SELW{1'b0}} : (gidx_s + SELW'(1));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; asynchronous clear discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= {SELW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_sel_q   <= {SELW{1'b0}};
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: directed vector table, hand sequences and a
// randomized phase against a scan-based reference model (RR and fixed DUTs).
module tb_mux_rr_nx1;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    localparam logic [N*WIDTH-1:0] DATA_STD = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    localparam logic [N*WIDTH-1:0] DATA_5A  = {8'hD3, 8'h5A, 8'hB1, 8'hA0};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       tb_valid;
    logic [N*WIDTH-1:0] tb_data;
    logic               tb_ordy;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_nx1_if #(.N(N), .WIDTH(WIDTH)) bus_rr ();
    mux_rr_nx1_if #(.N(N), .WIDTH(WIDTH)) bus_fx ();

    assign bus_rr.in_valid  = tb_valid;
    assign bus_rr.in_data   = tb_data;
    assign bus_rr.out_ready = tb_ordy;
    assign bus_fx.in_valid  = tb_valid;
    assign bus_fx.in_data   = tb_data;
    assign bus_fx.out_ready = tb_ordy;

    mux_rr_nx1 #(.N(N), .WIDTH(WIDTH), .MODE(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr.slave)
    );

    mux_rr_nx1 #(.N(N), .WIDTH(WIDTH), .MODE(0)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fx.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0 = fixed, 1 = round-robin)
    int               m_ptr  [2];
    logic             m_ov   [2];
    logic [WIDTH-1:0] m_data [2];
    int               m_sel  [2];
    int               g_s    [2];

    // Winning channel by scanning from the pointer with modulo arithmetic.
    function automatic int model_grant(input int mode, input int ptr, input logic ov,
                                       input logic [N-1:0] v, input logic ordy);
        int idx;
        if (ov && !ordy) return -1;
        for (int i = 0; i < N; i++) begin
            idx = (mode == 1) ? (ptr + i) % N : i;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            g_s[m] = model_grant(m, m_ptr[m], m_ov[m], tb_valid, tb_ordy);
        end
    end

    function automatic logic [N-1:0] exp_ready(input int m);
        if (!rst_n || g_s[m] < 0) return {N{1'b0}};
        return N'(1) << g_s[m];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_ptr[m]  <= 0;
                m_ov[m]   <= 1'b0;
                m_data[m] <= '0;
                m_sel[m]  <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (g_s[m] >= 0) begin
                    m_ov[m]   <= 1'b1;
                    m_sel[m]  <= g_s[m];
                    m_data[m] <= tb_data[g_s[m]*WIDTH +: WIDTH];
                    m_ptr[m]  <= (m == 1) ? (g_s[m] + 1) % N : 0;
                end else if (m_ov[m] && tb_ordy) begin
                    m_ov[m] <= 1'b0;
                end
            end
        end
    end

    // ---------------- directed vector table (RR DUT)
    typedef struct {
        logic [N-1:0]       valid;
        logic [N*WIDTH-1:0] data;
        logic               ordy;
        logic [N-1:0]       exp_ready;
        logic               exp_ov;
        logic [SELW-1:0]    exp_sel;
        logic [WIDTH-1:0]   exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                                input logic r, input logic [N-1:0] er, input logic eov,
                                input logic [SELW-1:0] es, input logic [WIDTH-1:0] ed);
        vec_t t;
        t.valid = v; t.data = d; t.ordy = r; t.exp_ready = er;
        t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed;
        return t;
    endfunction

    initial begin
        // round-robin sweep
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3));
        // back-pressure with 5A from ch2 held, then ch3 next
        vecs.push_back(mk(4'b0100, DATA_5A,  1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A));
        vecs.push_back(mk(4'b1111, DATA_5A,  1'b0, 4'b0000, 1'b1, 2'd2, 8'h5A));
        vecs.push_back(mk(4'b1111, DATA_5A,  1'b0, 4'b0000, 1'b1, 2'd2, 8'h5A));
        vecs.push_back(mk(4'b1111, DATA_5A,  1'b0, 4'b0000, 1'b1, 2'd2, 8'h5A));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3));
        // sparse traffic and pointer wrap 3 -> 0
        vecs.push_back(mk(4'b0010, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1));
        vecs.push_back(mk(4'b1000, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3));
        vecs.push_back(mk(4'b1001, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        vecs.push_back(mk(4'b1001, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3));
        // drain, idle, load into empty register while stalled downstream
        vecs.push_back(mk(4'b0000, DATA_STD, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3));
        vecs.push_back(mk(4'b0000, DATA_STD, 1'b0, 4'b0000, 1'b0, 2'd3, 8'hD3));
        vecs.push_back(mk(4'b0100, DATA_STD, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hC2));
        vecs.push_back(mk(4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hC2));
        vecs.push_back(mk(4'b0001, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));

        // ---- reset with all channels requesting
        rst_n    = 1'b0;
        tb_valid = 4'b1111;
        tb_data  = DATA_STD;
        tb_ordy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rr_out_valid", 64'(bus_rr.out_valid), 64'd0);
        check("rst_rr_out_data",  64'(bus_rr.out_data),  64'd0);
        check("rst_rr_out_sel",   64'(bus_rr.out_sel),   64'd0);
        check("rst_rr_in_ready",  64'(bus_rr.in_ready),  64'd0);
        check("rst_fx_out_valid", 64'(bus_fx.out_valid), 64'd0);
        check("rst_fx_in_ready",  64'(bus_fx.in_ready),  64'd0);
        rst_n = 1'b1;

        // ---- table
        foreach (vecs[i]) begin
            tb_valid = vecs[i].valid;
            tb_data  = vecs[i].data;
            tb_ordy  = vecs[i].ordy;
            #3;
            check($sformatf("vec%0d_in_ready", i), 64'(bus_rr.in_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 64'(bus_rr.out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_sel", i),   64'(bus_rr.out_sel),   64'(vecs[i].exp_sel));
            check($sformatf("vec%0d_out_data", i),  64'(bus_rr.out_data),  64'(vecs[i].exp_data));
        end

        // ---- fixed priority: ch1 wins every beat, ch2/ch3 starve
        for (int i = 0; i < 4; i++) begin
            tb_valid = 4'b1110;
            tb_data  = DATA_STD;
            tb_ordy  = 1'b1;
            #3;
            check("fx_in_ready", 64'(bus_fx.in_ready), 64'(4'b0010));
            @(posedge clk);
            #1;
            check("fx_out_valid", 64'(bus_fx.out_valid), 64'd1);
            check("fx_out_sel",   64'(bus_fx.out_sel),   64'd1);
            check("fx_out_data",  64'(bus_fx.out_data),  64'(8'hB1));
        end

        // ---- async reset mid-stream (RR pointer at 2 beforehand)
        tb_valid = 4'b0010;
        @(posedge clk);
        #1;
        check("pre_arst_rr_out_valid", 64'(bus_rr.out_valid), 64'd1);
        check("pre_arst_rr_out_sel",   64'(bus_rr.out_sel),   64'd1);
        tb_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rr_out_valid", 64'(bus_rr.out_valid), 64'd0);
        check("arst_fx_out_valid", 64'(bus_fx.out_valid), 64'd0);
        check("arst_rr_out_sel",   64'(bus_rr.out_sel),   64'd0);
        check("arst_rr_out_data",  64'(bus_rr.out_data),  64'd0);
        check("arst_rr_in_ready",  64'(bus_rr.in_ready),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("post_arst_in_ready", 64'(bus_rr.in_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        check("post_arst_out_sel",  64'(bus_rr.out_sel),  64'd0);
        check("post_arst_out_data", 64'(bus_rr.out_data), 64'(8'hA0));

        // ---- randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            tb_valid = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            tb_data  = N*WIDTH'($urandom);
            tb_ordy  = ($urandom_range(0, 3) != 0);
            #3;
            check("rnd_rr_in_ready",  64'(bus_rr.in_ready),  64'(exp_ready(1)));
            check("rnd_fx_in_ready",  64'(bus_fx.in_ready),  64'(exp_ready(0)));
            check("rnd_rr_out_valid", 64'(bus_rr.out_valid), 64'(m_ov[1]));
            check("rnd_rr_out_sel",   64'(bus_rr.out_sel),   64'(m_sel[1]));
            check("rnd_rr_out_data",  64'(bus_rr.out_data),  64'(m_data[1]));
            check("rnd_fx_out_valid", 64'(bus_fx.out_valid), 64'(m_ov[0]));
            check("rnd_fx_out_sel",   64'(bus_fx.out_sel),   64'(m_sel[0]));
            check("rnd_fx_out_data",  64'(bus_fx.out_data),  64'(m_data[0]));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised successor to the fixed 4:1 selector. Merges N input channels of WIDTH-bit data into one output stream using valid/ready handshakes.
- Arbitration is round-robin or fixed-priority, chosen by parameter. The output is registered.
- Used wherever several producers share one consumer, e.g. bus merge ahead of a shared datapath or FIFO.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel (1..64).
- MODE, 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- SELW, clog2(N), width of the channel-index output (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, RR pointer ptr=0. During reset, in_ready=0.
- Transfers:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge.
  - Output transfer: out_valid && out_ready.
- Load condition: load = !out_valid || out_ready. This is combinational; in_ready may depend on out_ready in the same cycle.
- Grant (combinational):
  - MODE=1: first asserted in_valid scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - MODE=0: lowest asserted index.
  - in_ready[i] = load && grant[i]. No grant when in_valid == 0.
- On an input transfer from channel g: out_data <= channel g data, out_sel <= g, out_valid <= 1. If MODE=1, ptr <= (g+1) mod N, wrapping N-1 -> 0. ptr is unchanged when there is no transfer.
- Output transfer with no new input transfer: out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous output and input transfer: the new beat replaces the old in the same edge, with no bubble. This sustains 1 beat/cycle.
- Back-pressure:
  - out_valid=1 && out_ready=0: all in_ready=0. Output register holds; ptr holds.
  - Input valids may change freely while stalled. The grant is re-evaluated every cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Fairness (MODE=1): with all N channels continuously valid and out_ready=1, grants go 0,1,...,N-1,0,... Each channel waits at most N-1 beats.
- Reset mid-operation: any pending beat is discarded and ptr returns to 0. No partial state survives.
- N not a power of two: ptr and out_sel never take values >= N.
- Width rules: no arithmetic on data; it passes bit-exact.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - clog2 function (returns 1 for N=2).
- Sub-module rr_arbiter, parameters N and MODE:
  - Inputs: req[N], ptr; outputs: one-hot grant[N] and index gidx.
  - Purely combinational (double-width rotate-and-priority-encode).
- ptr register and output register live in mux_nx1_rr.

Test Plan:
- Reset: rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Release, then the first grant goes to channel 0.
- Round-robin sweep: N=4, in_valid=4'b1111, data A0/B1/C2/D3, out_ready=1 held. Over 8 cycles: out_sel=0,1,2,3,0,1,2,3; out_data matches; out_valid stays 1 with no bubbles.
- Back-pressure: beat 8'h5A from ch2 in the register, out_ready=0 for 3 cycles -> in_ready=0, out_data=8'h5A and out_sel=2 held. Raise out_ready -> next grant goes to ch3 (ptr=3), not ch0.
- Sparse/wrap: only ch3 valid, then only ch0 valid -> ptr wraps 3->0, and ch0 is granted in the following cycle.
- Fixed mode: MODE=0, in_valid=4'b1110 continuously -> out_sel=1 every beat; ch2 and ch3 starve (expected).
- Async reset mid-stream: assert rst_n=0 between clock edges with out_valid=1 -> out_valid drops immediately without waiting for an edge, and ptr=0 after release.
